// File: rtl/ctrl_issue_unit.sv
// Decode-to-execute issue stage: registers decoded controls into E and holds
// multi-cycle OP-FP instructions in E for FP_LAT cycles, with perf counters.
module ctrl_issue_unit #(
  parameter int FP_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [6:0]       op,
  input  logic             stall_in,
  input  logic             flush,
  output logic             reg_write_e,
  output logic             mem_write_e,
  output logic             alu_src_e,
  output logic             branch_e,
  output logic             jump_e,
  output logic             reg_write_f_e,
  output logic             mem_src_e,
  output logic             d_src_e,
  output logic [1:0]       imm_src_e,
  output logic [1:0]       result_src_e,
  output logic [1:0]       alu_op_e,
  output logic             valid_e,
  output logic             illegal_e,
  output logic             stall_d,
  output logic             fpu_busy,
  output logic             fp_done_e,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] fp_stall_cnt
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_FLW = 7'b0000111;
  localparam logic [6:0] OP_FSW = 7'b0100111;
  localparam logic [6:0] OP_FP  = 7'b1010011;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
    logic       reg_write_f;
    logic       mem_src;
    logic       d_src;
  } ctrl_t;

  typedef enum logic {IDLE, FP_BUSY} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  ctrl_t            ctrl_q, ctrl_d, dec;
  logic             valid_q, valid_d;
  logic             illegal_q, illegal_d;
  logic             dec_illegal;
  logic             accept;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] fp_stall_cnt_q, fp_stall_cnt_d;

  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    case (op)
      OP_LW:  begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.result_src = 2'b01; end
      OP_SW:  begin dec.imm_src = 2'b01; dec.alu_src = 1'b1; dec.mem_write = 1'b1; end
      OP_R:   begin dec.reg_write = 1'b1; dec.alu_op = 2'b10; end
      OP_BEQ: begin dec.imm_src = 2'b10; dec.branch = 1'b1; dec.alu_op = 2'b01; end
      OP_I:   begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 2'b10; end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = 2'b11;
        dec.result_src = 2'b10;
        dec.jump       = 1'b1;
      end
      OP_FLW: begin dec.alu_src = 1'b1; dec.result_src = 2'b01; dec.reg_write_f = 1'b1; end
      OP_FSW: begin dec.imm_src = 2'b01; dec.alu_src = 1'b1; dec.mem_write = 1'b1; dec.mem_src = 1'b1; end
      OP_FP:  begin dec.reg_write_f = 1'b1; dec.d_src = 1'b1; end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign stall_d = (state_q == FP_BUSY);
  assign accept  = instr_valid & ~stall_d & ~stall_in & ~flush;

  // Priority: flush, then FP_BUSY hold, then stall_in bubble, then accept.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ctrl_d         = '0;
    valid_d        = 1'b0;
    illegal_d      = 1'b0;
    instr_cnt_d    = accept ? instr_cnt_q + CNT_W'(1) : instr_cnt_q;
    fp_stall_cnt_d = (state_q == FP_BUSY) ? fp_stall_cnt_q + CNT_W'(1) : fp_stall_cnt_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == FP_BUSY) begin
      ctrl_d    = ctrl_q;
      valid_d   = valid_q;
      illegal_d = illegal_q;
      if (cnt_q == 4'd1) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (accept) begin
      ctrl_d    = dec;
      valid_d   = 1'b1;
      illegal_d = dec_illegal;
      if (op == OP_FP && FP_LAT > 1) begin
        state_d = FP_BUSY;
        cnt_d   = 4'(FP_LAT - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      ctrl_q         <= '0;
      valid_q        <= 1'b0;
      illegal_q      <= 1'b0;
      instr_cnt_q    <= '0;
      fp_stall_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ctrl_q         <= ctrl_d;
      valid_q        <= valid_d;
      illegal_q      <= illegal_d;
      instr_cnt_q    <= instr_cnt_d;
      fp_stall_cnt_q <= fp_stall_cnt_d;
    end
  end

  assign reg_write_e   = ctrl_q.reg_write;
  assign imm_src_e     = ctrl_q.imm_src;
  assign alu_src_e     = ctrl_q.alu_src;
  assign mem_write_e   = ctrl_q.mem_write;
  assign result_src_e  = ctrl_q.result_src;
  assign branch_e      = ctrl_q.branch;
  assign jump_e        = ctrl_q.jump;
  assign alu_op_e      = ctrl_q.alu_op;
  assign reg_write_f_e = ctrl_q.reg_write_f;
  assign mem_src_e     = ctrl_q.mem_src;
  assign d_src_e       = ctrl_q.d_src;
  assign valid_e       = valid_q;
  assign illegal_e     = illegal_q;
  assign fpu_busy      = (state_q == FP_BUSY);
  assign fp_done_e     = valid_q & ctrl_q.d_src & (state_q == IDLE);
  assign instr_cnt     = instr_cnt_q;
  assign fp_stall_cnt  = fp_stall_cnt_q;

endmodule
